// File: rtl/ad_sample_pkg.sv
// Shared types for the AD sample buffer: capture FSM state encoding and
// source-select codes for the sample mux.
package ad_sample_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] SRC_ADC = 2'd0;
  localparam logic [1:0] SRC_SIN = 2'd1;
  localparam logic [1:0] SRC_COS = 2'd2;

  // DDS references never overflow, so OTR is only meaningful on ADC captures.
  function automatic logic src_is_ref(input logic [1:0] src);
    return (src == SRC_SIN) || (src == SRC_COS);
  endfunction

endpackage

// File: rtl/ad_sample_buffer_if.sv
// Capture control, sample inputs, status and read port of the AD sample buffer.
// The master side drives control/samples; the slave side is the buffer itself.
interface ad_sample_buffer_if #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 11,
  parameter int DECIM_W = 8,
  parameter int OVF_W   = 8
);

  logic               Enable;
  logic [1:0]         SrcSel;
  logic [ADDR_W-1:0]  NumSamp;
  logic [DECIM_W-1:0] Decim;
  logic               OTR;
  logic [DATA_W-1:0]  DataIn;
  logic [DATA_W-1:0]  SinRef;
  logic [DATA_W-1:0]  CosRef;
  logic [ADDR_W-1:0]  RdAddr;
  logic [DATA_W-1:0]  RdData;
  logic               Busy;
  logic               Done;
  logic [ADDR_W-1:0]  SampCnt;
  logic               OvfFlag;
  logic [OVF_W-1:0]   OvfCnt;

  modport master (
    output Enable, SrcSel, NumSamp, Decim, OTR, DataIn, SinRef, CosRef, RdAddr,
    input  RdData, Busy, Done, SampCnt, OvfFlag, OvfCnt
  );

  modport slave (
    input  Enable, SrcSel, NumSamp, Decim, OTR, DataIn, SinRef, CosRef, RdAddr,
    output RdData, Busy, Done, SampCnt, OvfFlag, OvfCnt
  );

endinterface

// File: rtl/ad_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port with
// read-before-write behaviour; out-of-range reads return zero.
module ad_sample_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 500,
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              rd_in_range;
  logic [RAM_AW-1:0] wr_idx;
  logic [RAM_AW-1:0] rd_idx;

  assign wr_in_range = (wr_addr < DEPTH_A);
  assign rd_in_range = (rd_addr < DEPTH_A);
  assign wr_idx      = wr_addr[RAM_AW-1:0];
  assign rd_idx      = rd_addr[RAM_AW-1:0];

  // NOTE: the array has no reset so it can map onto block RAM; contents
  // survive aborts and resets, only the output register is cleared.
  always_ff @(posedge CLK) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments make the read sample the array before the
  // same-edge write lands, which is exactly the read-before-write behaviour.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/ad_sample_buffer.sv
// AD waveform capture buffer: arms on Enable, stores N decimated samples from
// the selected source into RAM, tracks ADC overflow and exposes a read port.
module ad_sample_buffer
  import ad_sample_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int DEPTH   = 500,
  parameter int ADDR_W  = 11,
  parameter int DECIM_W = 8,
  parameter int OVF_W   = 8
) (
  input logic               CLK,
  input logic               RST,
  ad_sample_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t             state;
  state_t             state_nxt;
  logic               busy_c;
  logic               done_c;

  logic [1:0]         src_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dec_cnt;
  logic [ADDR_W-1:0]  num_q;
  logic [ADDR_W-1:0]  samp_cnt;
  logic [OVF_W-1:0]   ovf_cnt;
  logic               ovf_flag;

  logic [ADDR_W-1:0]  num_eff;
  logic               arm_now;
  logic               sampling;
  logic               store;
  logic               last_store;
  logic [DATA_W-1:0]  src_data;

  assign num_eff = ((bus.NumSamp == '0) || (bus.NumSamp > DEPTH_A)) ? DEPTH_A
                                                                    : bus.NumSamp;

  // The ARM cycle already evaluates the store condition, which is what puts
  // the first sample on the second edge after Enable is seen.
  assign arm_now    = (state == IDLE) && bus.Enable;
  assign sampling   = ((state == ARM) || (state == CAPTURE)) && bus.Enable;
  assign store      = sampling && (dec_cnt == decim_q);
  assign last_store = store && ((samp_cnt + ADDR_W'(1)) == num_q);

  always_comb begin
    src_data = bus.DataIn;
    case (src_q)
      SRC_SIN: src_data = bus.SinRef;
      SRC_COS: src_data = bus.CosRef;
      default: src_data = bus.DataIn;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    if (!bus.Enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:         state_nxt = ARM;
        ARM, CAPTURE: state_nxt = last_store ? DONE : CAPTURE;
        DONE:         state_nxt = DONE;
        default:      state_nxt = IDLE;
      endcase
    end
    busy_c = (state == ARM) || (state == CAPTURE);
    done_c = (state == DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      src_q    <= SRC_ADC;
      decim_q  <= '0;
      dec_cnt  <= '0;
      num_q    <= '0;
      samp_cnt <= '0;
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (arm_now) begin
      src_q    <= bus.SrcSel;
      decim_q  <= bus.Decim;
      num_q    <= num_eff;
      dec_cnt  <= '0;
      samp_cnt <= '0;
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (sampling) begin
      if (store) begin
        dec_cnt  <= '0;
        samp_cnt <= samp_cnt + ADDR_W'(1);
        if (bus.OTR && !src_is_ref(src_q)) begin
          ovf_flag <= 1'b1;
          if (ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + OVF_W'(1);
          end
        end
      end else begin
        dec_cnt <= dec_cnt + DECIM_W'(1);
      end
    end
  end

  ad_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (store),
    .wr_addr (samp_cnt),
    .wr_data (src_data),
    .rd_addr (bus.RdAddr),
    .rd_data (bus.RdData)
  );

  assign bus.Busy    = busy_c;
  assign bus.Done    = done_c;
  assign bus.SampCnt = samp_cnt;
  assign bus.OvfFlag = ovf_flag;
  assign bus.OvfCnt  = ovf_cnt;

endmodule

// File: doc/ad_sample_buffer.md
Name: ad_sample_buffer

Overview:
- Parametrised successor of the direct AD waveform sampler.
- Captures a run-time programmable number of samples (up to DEPTH) from a selectable source: ADC, DDS sine reference or DDS cosine reference.
- Supports an optional decimation factor, tracks ADC overflow (OTR) per capture, and exposes the stored waveform on a registered read port for the downstream demodulator.
- Sits between the AD9240 interface and the demodulation/DSP logic in the 10 MHz domain.

Parameters:
DATA_W, 14, sample width (ADC and DDS refs)
DEPTH, 500, buffer depth; maximum samples per capture
ADDR_W, 11, address/count width; requires 2**ADDR_W > DEPTH
DECIM_W, 8, width of decimation control
OVF_W, 8, width of saturating overflow counter

Ports:
CLK  in  1  system clock (10 MHz)
RST  in  1  asynchronous reset, active-low
Enable  in  1  level; high arms/holds a capture, low aborts/clears
SrcSel  in  2  0=DataIn, 1=SinRef, 2=CosRef, 3=DataIn
NumSamp  in  ADDR_W  samples to capture; 0 or >DEPTH means DEPTH
Decim  in  DECIM_W  store one sample every Decim+1 clocks
OTR  in  1  ADC overflow flag, aligned with DataIn
DataIn  in  DATA_W  AD9240 sample
SinRef  in  DATA_W  DDS sine reference
CosRef  in  DATA_W  DDS cosine reference
RdAddr  in  ADDR_W  buffer read address
RdData  out  DATA_W  registered read data
Busy  out  1  capture in progress
Done  out  1  capture complete; held until Enable low
SampCnt  out  ADDR_W  samples stored in current/last capture
OvfFlag  out  1  sticky: OTR seen on a stored sample this capture
OvfCnt  out  OVF_W  stored samples with OTR=1, saturating

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; Busy, Done, OvfFlag=0; SampCnt, OvfCnt, RdData=0.
  - Buffer RAM is not reset.
- States: IDLE -> ARM -> CAPTURE -> DONE.
  - IDLE: waits for Enable=1, then goes to ARM.
  - ARM (1 cycle): latches SrcSel, Decim, and effective N = (NumSamp==0 || NumSamp>DEPTH) ? DEPTH : NumSamp. Clears SampCnt, OvfCnt, OvfFlag and the decimation counter. Sets Busy=1.
  - CAPTURE: on each cycle where the decimation counter equals latched Decim, writes the selected sample to RAM[SampCnt], increments SampCnt, and resets the counter; otherwise increments the counter. Decim=0 stores every clock.
  - When SampCnt reaches N, the same edge that stores the last sample goes to DONE with Busy=0 and Done=1.
  - DONE: holds until Enable=0. Sampling does not restart while Enable stays high.
- Enable=0 in any state: on the next edge go to IDLE, with Busy=0 and Done=0. SampCnt, OvfFlag and OvfCnt keep their last values until the next ARM. RAM contents are retained.
- Abort mid-capture: the partial data remains readable; SampCnt gives the number of valid entries.
- Overflow tracking:
  - OTR is sampled only on store cycles; OvfFlag is set and OvfCnt increments, saturating at 2**OVF_W-1.
  - With SrcSel=1 or 2, OTR is ignored.
- Source mux is combinational; the stored value is the mux output on the store-cycle edge.
- Read port:
  - RdData = RAM[RdAddr] one cycle after RdAddr, valid in every state.
  - RdAddr >= DEPTH returns 0.
  - A simultaneous read and write to the same address returns the old data (read-before-write).
- Latency: first sample stored 2 edges after Enable rises (IDLE->ARM, ARM->CAPTURE store). Done rises N*(Decim+1)+1 edges after Enable is first sampled high.

Decomposition:
- Package ad_sample_pkg: state encoding (IDLE/ARM/CAPTURE/DONE, 2 bits) and SrcSel constants SRC_ADC=0, SRC_SIN=1, SRC_COS=2.
- Sub-module ad_sample_ram: simple dual-port RAM, DEPTH x DATA_W, with one write port, one registered read port and read-before-write behaviour; maps to M9K.
- Control FSM, source mux, decimator and overflow logic live in the top-level module.

Test Plan:
- Reset mid-CAPTURE (after 100 of 500 samples) -> all outputs 0 at once; with Enable held high, a fresh ARM follows reset release; SampCnt restarts at 0.
- Enable=1, NumSamp=0, Decim=0, DataIn ramp 0..499 -> Done rises on edge 501 after Enable; SampCnt=500; reading RdAddr 0..499 returns 0..499 with 1-cycle latency.
- NumSamp=10, Decim=3, SrcSel=1, SinRef incrementing each clock from 0 -> stored values 0,4,8..36 (after ARM offset); Done after 41 edges; OTR pulses ignored, OvfCnt=0.
- NumSamp=600 (>DEPTH), OTR=1 on every 50th stored sample -> N=500; OvfFlag=1, OvfCnt=10; OvfW=2 variant saturates at 3.
- Enable dropped after 200 stores -> Busy=0, Done=0 next edge; SampCnt=200; RAM[0..199] readable; re-assert -> new capture overwrites from address 0.
- Read of address k on the cycle it is written -> old value returned; RdAddr=DEPTH -> RdData=0.
